fx2_slave_fifo_model: RTL and testbench

- Synthesizable responder model of the CY7C68013 slave-FIFO interface. It is the FX2 side of the link the FPGA USB master drives.
- Provides EP2 (host→FPGA, OUT) and EP6 (FPGA→host, IN) FIFOs with FX2 strobe/flag semantics.
- A simple host-side valid/ready port stands in for the PC: it fills EP2 and drains committed EP6 packets.
- Used for on-chip loopback and as the bench counterpart for the USB master block.

---
 rtl/fx2_slave_fifo_model.sv | 139 +++++++++++++
 tb/tb_fx2_slave_fifo_model.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO responder: EP2 (OUT) and EP6 (IN) FIFOs, host-side port.
// Define FX2_PROTOCOL_CHECK_EN to add sticky o_proto_err[3:0].
module fx2_slave_fifo_model #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  parameter int LOG_DEPTH  = 9,
  parameter int PKT_WORDS  = 256
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst_n,
  inout  wire  [DATA_WIDTH-1:0] io_usb_data,
  input  logic [1:0]            i_usb_addr,
  input  logic                  i_usb_slrd,
  input  logic                  i_usb_slwr,
  input  logic                  i_usb_sloe,
  input  logic                  i_usb_pkend,
  output logic                  o_usb_flaga,
  output logic                  o_usb_flagd,
  input  logic                  i_host_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_host_wr_data,
  output logic                  o_host_wr_ready,
  output logic                  o_host_rd_valid,
  output logic [DATA_WIDTH-1:0] o_host_rd_data,
  input  logic                  i_host_rd_ready,
  output logic                  o_host_pkt_done
`ifdef FX2_PROTOCOL_CHECK_EN
  ,
  output logic [3:0]            o_proto_err
`endif
);

  localparam int PW = LOG_DEPTH + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t PKT_P   = ptr_t'(PKT_WORDS);

  logic [DATA_WIDTH-1:0] ep2_mem [DEPTH];
  logic [DATA_WIDTH-1:0] ep6_mem [DEPTH];

  ptr_t ep2_wp_q, ep2_wp_d, ep2_rp_q, ep2_rp_d;
  ptr_t ep6_wp_q, ep6_wp_d, ep6_rp_q, ep6_rp_d;
  ptr_t ep6_cp_q, ep6_cp_d, ep6_unc;
  logic flaga_q, flaga_d, flagd_q, flagd_d;
  logic done_q, done_d, commit;

  logic ep2_empty, ep2_full, ep6_full;
  logic ep2_pop, host_push, ep6_push, host_pop, pkend;
  logic [DATA_WIDTH-1:0] ep2_head;

  assign ep2_empty = (ep2_wp_q == ep2_rp_q);
  assign ep2_full  = (ep2_wp_q[PW-1] != ep2_rp_q[PW-1]) &&
                     (ep2_wp_q[PW-2:0] == ep2_rp_q[PW-2:0]);
  assign ep6_full  = (ep6_wp_q[PW-1] != ep6_rp_q[PW-1]) &&
                     (ep6_wp_q[PW-2:0] == ep6_rp_q[PW-2:0]);

  assign ep2_head = ep2_mem[ep2_rp_q[PW-2:0]];

  // Bus is driven (0 when empty) whenever EP2 is selected with SLOE low.
  assign io_usb_data =
    (!i_usb_sloe && i_usb_addr == 2'b00) ?
    (ep2_empty ? '0 : ep2_head) : 'z;

  assign ep2_pop   = !i_usb_slrd && i_usb_addr == 2'b00 && !ep2_empty;
  assign ep6_push  = !i_usb_slwr && i_usb_addr == 2'b10 && !ep6_full;
  assign pkend     = !i_usb_pkend && i_usb_addr == 2'b10;
  assign host_push = i_host_wr_valid && !ep2_full;
  assign host_pop  = o_host_rd_valid && i_host_rd_ready;

  assign o_host_wr_ready = !ep2_full;
  assign o_host_rd_valid = (ep6_cp_q != ep6_rp_q);
  assign o_host_rd_data  = ep6_mem[ep6_rp_q[PW-2:0]];
  assign o_usb_flaga     = flaga_q;
  assign o_usb_flagd     = flagd_q;
  assign o_host_pkt_done = done_q;

  always_comb begin
    ep2_wp_d = ep2_wp_q + ptr_t'(host_push);
    ep2_rp_d = ep2_rp_q + ptr_t'(ep2_pop);
    ep6_wp_d = ep6_wp_q + ptr_t'(ep6_push);
    ep6_rp_d = ep6_rp_q + ptr_t'(host_pop);
    // A push on the pkend edge is part of the committed packet.
    ep6_unc  = ep6_wp_d - ep6_cp_q;
    commit   = pkend || (ep6_unc == PKT_P);
    ep6_cp_d = commit ? ep6_wp_d : ep6_cp_q;
    done_d   = commit;
    flaga_d  = (ep2_wp_d != ep2_rp_d);
    flagd_d  = ((ep6_wp_d - ep6_rp_d) != DEPTH_P);
  end

  always_ff @(posedge i_usb_ifclk) begin
    if (!i_rst_n) begin
      ep2_wp_q <= '0;
      ep2_rp_q <= '0;
      ep6_wp_q <= '0;
      ep6_rp_q <= '0;
      ep6_cp_q <= '0;
      flaga_q  <= 1'b0;
      flagd_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      ep2_wp_q <= ep2_wp_d;
      ep2_rp_q <= ep2_rp_d;
      ep6_wp_q <= ep6_wp_d;
      ep6_rp_q <= ep6_rp_d;
      ep6_cp_q <= ep6_cp_d;
      flaga_q  <= flaga_d;
      flagd_q  <= flagd_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge i_usb_ifclk) begin
    if (host_push)
      ep2_mem[ep2_wp_q[PW-2:0]] <= i_host_wr_data;
    if (ep6_push)
      ep6_mem[ep6_wp_q[PW-2:0]] <= io_usb_data;
  end

`ifdef FX2_PROTOCOL_CHECK_EN
  logic [3:0] err_q, err_d;

  always_comb begin
    err_d = err_q | {
      !i_usb_sloe && i_usb_addr == 2'b10,
      !i_usb_slrd && !i_usb_slwr,
      !i_usb_slwr && i_usb_addr == 2'b10 && ep6_full,
      !i_usb_slrd && i_usb_addr == 2'b00 && ep2_empty
    };
  end

  always_ff @(posedge i_usb_ifclk) begin
    if (!i_rst_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign o_proto_err = err_q;
`endif

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model.
// Define FX2_PROTOCOL_CHECK_EN to also cover o_proto_err.
module tb_fx2_slave_fifo_model;

  logic        clk = 1'b0;
  logic        rst_n;
  wire  [15:0] usb_data;
  logic        fpga_oe;
  logic [15:0] fpga_data;
  logic [1:0]  addr;
  logic        slrd, slwr, sloe, pkend;
  logic        flaga, flagd;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        pkt_done;
`ifdef FX2_PROTOCOL_CHECK_EN
  logic [3:0]  proto_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign usb_data = fpga_oe ? fpga_data : 'z;

  fx2_slave_fifo_model dut (
    .i_usb_ifclk     (clk),
    .i_rst_n         (rst_n),
    .io_usb_data     (usb_data),
    .i_usb_addr      (addr),
    .i_usb_slrd      (slrd),
    .i_usb_slwr      (slwr),
    .i_usb_sloe      (sloe),
    .i_usb_pkend     (pkend),
    .o_usb_flaga     (flaga),
    .o_usb_flagd     (flagd),
    .i_host_wr_valid (wr_valid),
    .i_host_wr_data  (wr_data),
    .o_host_wr_ready (wr_ready),
    .o_host_rd_valid (rd_valid),
    .o_host_rd_data  (rd_data),
    .i_host_rd_ready (rd_ready),
    .o_host_pkt_done (pkt_done)
`ifdef FX2_PROTOCOL_CHECK_EN
    ,
    .o_proto_err     (proto_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fpga_oe  = 1'b0;
    addr     = 2'b01;
    slrd     = 1'b1;
    slwr     = 1'b1;
    sloe     = 1'b1;
    pkend    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    int d0, d1, dn, errs;
    fpga_data = '0;
    wr_data   = '0;
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_flaga", flaga, 0);
    chk("rst_flagd", flagd, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // Reset mid-transfer: EP2 5 words, EP6 3 uncommitted
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'(16'h0100 + i);
      cyc();
    end
    wr_valid = 1'b0;
    addr = 2'b10;
    fpga_oe = 1'b1;
    slwr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fpga_data = 16'(16'h0200 + i);
      cyc();
    end
    idle();
    chk("mid_flaga_before", flaga, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_flaga", flaga, 0);
    chk("mid_flagd", flagd, 1);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_pkt_done", pkt_done, 0);
    cyc();
    chk("mid_pkt_done2", pkt_done, 0);
    chk("mid_rd_valid2", rd_valid, 0);

    // EP2 read of 4 host words
    wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 16'(i);
      cyc();
    end
    wr_valid = 1'b0;
    sloe = 1'b0;
    addr = 2'b00;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      slrd = 1'b0;
      @(negedge clk);
      chk($sformatf("ep2_word%0d", i), usb_data, 32'(i));
      chk($sformatf("ep2_flaga_pre%0d", i), flaga, 1);
      cyc();
      slrd = 1'b1;
      cyc();
    end
    chk("ep2_flaga_drop", flaga, 0);
    slrd = 1'b0;
    @(negedge clk);
    chk("ep2_empty_bus", usb_data, 0);
    cyc();
    slrd = 1'b1;
    chk("ep2_5th_flaga", flaga, 0);
    wr_valid = 1'b1;
    wr_data = 16'h0077;
    cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("ep2_after_5th", usb_data, 32'h0077);
    slrd = 1'b0;
    cyc();
    idle();
    chk("ep2_reempty", flaga, 0);

    // EP6 pkend commit of two words
    addr = 2'b10;
    fpga_oe = 1'b1;
    slwr = 1'b0;
    fpga_data = 16'hA5A5;
    cyc();
    fpga_data = 16'h5A5A;
    cyc();
    slwr = 1'b1;
    chk("pk_valid_before", rd_valid, 0);
    pkend = 1'b0;
    cyc();
    pkend = 1'b1;
    chk("pk_done", pkt_done, 1);
    chk("pk_valid", rd_valid, 1);
    chk("pk_word0", rd_data, 32'hA5A5);
    rd_ready = 1'b1;
    cyc();
    chk("pk_done_once", pkt_done, 0);
    chk("pk_word1", rd_data, 32'h5A5A);
    chk("pk_valid1", rd_valid, 1);
    cyc();
    rd_ready = 1'b0;
    chk("pk_drained", rd_valid, 0);
    idle();
    cyc();

    // EP6 auto-commit at 256 and 512, then full
    addr = 2'b10;
    fpga_oe = 1'b1;
    slwr = 1'b0;
    d0 = -1;
    d1 = -1;
    dn = 0;
    for (int i = 0; i < 512; i++) begin
      fpga_data = 16'(16'h1000 + i);
      if (i == 511) chk("full_flagd_511", flagd, 1);
      cyc();
      if (pkt_done) begin
        if (dn == 0) d0 = i;
        else if (dn == 1) d1 = i;
        dn++;
      end
    end
    chk("auto_flagd_full", flagd, 0);
    chk("auto_first", d0, 255);
    chk("auto_second", d1, 511);
    fpga_data = 16'hDEAD;
    cyc();
    chk("auto_513_nodone", pkt_done, 0);
    chk("auto_count", dn, 2);
    idle();
    rd_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      if (!rd_valid || rd_data !== 16'(16'h1000 + i)) errs++;
      cyc();
    end
    rd_ready = 1'b0;
    chk("auto_drain_data", errs, 0);
    chk("auto_drain_empty", rd_valid, 0);
    chk("auto_flagd_back", flagd, 1);

    // Zero-length packet
    addr = 2'b10;
    pkend = 1'b0;
    cyc();
    pkend = 1'b1;
    chk("zlp_done", pkt_done, 1);
    chk("zlp_valid", rd_valid, 0);
    cyc();
    chk("zlp_done_off", pkt_done, 0);
    idle();

    // EP2 at 511: simultaneous host push and FPGA pop
    wr_valid = 1'b1;
    for (int i = 0; i < 511; i++) begin
      wr_data = 16'(16'h3000 + i);
      cyc();
    end
    wr_valid = 1'b0;
    chk("cc_ready_511", wr_ready, 1);
    chk("cc_flaga_511", flaga, 1);
    wr_valid = 1'b1;
    wr_data = 16'hBEEF;
    sloe = 1'b0;
    addr = 2'b00;
    slrd = 1'b0;
    @(negedge clk);
    chk("cc_head", usb_data, 32'h3000);
    cyc();
    slrd = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("cc_head_next", usb_data, 32'h3001);
    chk("cc_ready_still", wr_ready, 1);
    chk("cc_flaga", flaga, 1);
    cyc();
    wr_valid = 1'b1;
    wr_data = 16'h4444;
    cyc();
    wr_valid = 1'b0;
    chk("cc_now_full", wr_ready, 0);
    idle();

`ifdef FX2_PROTOCOL_CHECK_EN
    chk("pe_bit2_clear", proto_err[2], 0);
    addr = 2'b01;
    slrd = 1'b0;
    slwr = 1'b0;
    cyc();
    idle();
    chk("pe_bit2_set", proto_err[2], 1);
    cyc();
    chk("pe_bit2_sticky", proto_err[2], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
